seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
Streaming controller for the serial sequence-detector function. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first, one bit per clock. An embedded Mealy matcher checks the bit stream against a runtime-programmable pattern, with overlapping matches allowed. The block counts matches and exposes the serialized bit stream, so it can also drive or observe a downstream serial detector.

Parameters:
DATA_W, 8, width of input words; bits per word serialized
PAT_W, 4, maximum pattern length in bits
CNT_W, 8, match counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  pattern/length write strobe; honoured only when busy=0
cfg_pattern  in  PAT_W  pattern; bit 0 = most recent bit
cfg_len  in  $clog2(PAT_W+1)  pattern length
clr_count  in  1  synchronous clear of match_count
in_valid  in  1  input word valid
in_data  in  DATA_W  input word
in_ready  out  1  controller can accept a word this cycle
bit_out  out  1  current serialized bit
bit_valid  out  1  bit_out is meaningful this cycle
match  out  1  Mealy match flag, combinational on the current bit and history
match_count  out  CNT_W  saturating count of matches
busy  out  1  serialization in progress

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low, on clk / rst_n.
- Reset values:
  - FSM = IDLE; in_ready=1; bit_valid=0; busy=0; match=0; match_count=0.
  - pattern=4'b1101 (zero-extended/truncated to PAT_W); len=PAT_W.
  - History register and fill counter cleared.
- FSM states:
  - IDLE: in_ready=1, bit_valid=0. When in_valid&&in_ready, latch in_data, set bit index to DATA_W-1, go to SHIFT.
  - SHIFT: bit_valid=1, busy=1, bit_out=word[index]. Index decrements each cycle.
  - On the cycle with index=0 (last bit), in_ready=1.
    - If in_valid is high that cycle, latch the new word and stay in SHIFT at index DATA_W-1, with no bubble.
    - Otherwise go to IDLE.
- Throughput and latency:
  - One word per DATA_W cycles.
  - First bit appears on bit_out the cycle after the handshake.
- Matching:
  - hist holds the last PAT_W-1 accepted bits.
  - cand = {hist, bit_out}, low len bits.
  - match = bit_valid && (fill >= len-1) && (cand[len-1:0] == pattern[len-1:0]).
  - On each bit_valid edge, shift bit_out into hist and increment fill (saturating at PAT_W).
  - History persists across word boundaries and across IDLE gaps.
  - Overlapping matches are counted.
- cfg_len clamping: 0 is treated as 1; values above PAT_W are treated as PAT_W.
- Configuration:
  - cfg_we while busy=0 loads pattern and len and clears hist and fill.
  - cfg_we while busy=1 is ignored entirely.
- Counter:
  - match_count increments on each cycle with match=1, saturating at 2^CNT_W-1.
  - clr_count sets the count to 0. If clr_count and match occur in the same cycle, clr wins: count=0, and match is still asserted.
- in_data is sampled only at the handshake. Changes while busy have no effect.
- Reset mid-word: immediate abort. All state returns to reset values and the partial word is discarded.

Test Plan:
1. Default pattern 1101, len 4, after reset; send 8'b1101_1010 → bit_out sequence 1,1,0,1,1,0,1,0; match=1 on bit cycles 4 and 7 only (1-based); match_count=2; back to IDLE, busy=0.
2. Cross-word history: send 8'b0000_0110, then after a 3-cycle idle gap send 8'b1000_0000 → match=1 only on the first bit cycle of the second word; match_count=1.
3. Back-to-back: hold in_valid=1 with two words → in_ready=1 exactly on each last-bit cycle; 16 consecutive bit_valid cycles with no gap.
4. Reconfigure: cfg_we with pattern=2'b11, len=2; send 8'hFF → 7 matches (bits 2..8); match_count=7. A cfg_we pulse while busy leaves pattern unchanged.
5. Saturation and clear (CNT_W=2): stream 8'hFF with len=1, pattern=1 → count saturates at 3. Assert clr_count together with a match → count=0 next cycle.
6. Async reset: drop rst_n at bit 3 of a word → bit_valid and busy fall immediately; match_count=0; after release in_ready=1 and the pattern is back to 1101.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// Stream interface for seq_detect_ctrl: parallel word input handshake plus serialized bit/match output.
interface seq_detect_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              bit_out;
  logic              bit_valid;
  logic              match;

  modport master (
    output in_valid, in_data,
    input  in_ready, bit_out, bit_valid, match
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, bit_out, bit_valid, match
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Word serializer (MSB-first) with an embedded programmable Mealy pattern matcher
// and a saturating match counter.
module seq_detect_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       clr_count,
  seq_detect_ctrl_if.slave           s,
  output logic [CNT_W-1:0]           match_count,
  output logic                       busy
);

  localparam int unsigned LEN_W = $clog2(PAT_W + 1);
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                ready_c;

  logic [PAT_W-1:0]    pat_q;
  logic [LEN_W-1:0]    len_q;
  logic [PAT_W-2:0]    hist_q;
  logic [LEN_W-1:0]    fill_q;
  logic [PAT_W-1:0]    cand_c;
  logic [PAT_W-1:0]    mask_c;
  logic [LEN_W-1:0]    len_clamp_c;
  logic                cfg_ok_c;
  logic                bit_valid_c;
  logic                match_c;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: a word accepted on the last bit reloads without a bubble
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    ready_c = (state_q == IDLE) || (idx_q == '0);
    case (state_q)
      IDLE: begin
        if (s.in_valid) begin
          word_d  = s.in_data;
          idx_d   = IDX_W'(DATA_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (idx_q == '0) begin
          if (s.in_valid) begin
            word_d = s.in_data;
            idx_d  = IDX_W'(DATA_W - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bit_valid_c = (state_q == SHIFT);
  assign busy        = bit_valid_c;
  assign s.in_ready  = ready_c;
  assign s.bit_valid = bit_valid_c;
  assign s.bit_out   = word_q[idx_q];

  // Matcher: compare the low len bits of {history, current bit} against the pattern
  always_comb begin
    cand_c = {hist_q, s.bit_out};
    mask_c = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask_c[i] = (LEN_W'(i) < len_q);
    end
    match_c = bit_valid_c && (fill_q >= (len_q - LEN_W'(1))) &&
              (((cand_c ^ pat_q) & mask_c) == '0);
  end

  assign s.match = match_c;

  assign cfg_ok_c    = cfg_we && !busy;
  assign len_clamp_c = (cfg_len == '0)           ? LEN_W'(1)     :
                       (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;

  // Pattern configuration and bit history; history spans word boundaries and idle gaps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= PAT_W'(4'b1101);
      len_q  <= LEN_W'(PAT_W);
      hist_q <= '0;
      fill_q <= '0;
    end else if (cfg_ok_c) begin
      pat_q  <= cfg_pattern;
      len_q  <= len_clamp_c;
      hist_q <= '0;
      fill_q <= '0;
    end else if (bit_valid_c) begin
      hist_q <= cand_c[PAT_W-2:0];
      if (fill_q != LEN_W'(PAT_W)) fill_q <= fill_q + LEN_W'(1);
    end
  end

  // Saturating match counter; clear takes priority over a same-cycle match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_count <= '0;
    end else if (clr_count) begin
      match_count <= '0;
    end else if (match_c && (match_count != {CNT_W{1'b1}})) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule
